// File: rtl/leibniz_pi_sequencer_pkg.sv
// Shared constants for the Leibniz pi sequencer: FSM encoding, fixed-point widths and 1.0.
package leibniz_pi_sequencer_pkg;

    localparam int L_WIDTH_IN_DEF   = 16;
    localparam int L_WIDTH_FRAC_DEF = 16;
    localparam int L_ACC_W          = L_WIDTH_FRAC_DEF + 2;
    localparam int L_PI_W           = L_WIDTH_FRAC_DEF + 3;

    localparam logic [L_ACC_W-1:0] L_ONE_Q = {1'b0, 1'b1, {L_WIDTH_FRAC_DEF{1'b0}}};

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_ACC   = 3'd4;
    localparam logic [2:0] S_FIN   = 3'd5;

endpackage

// File: rtl/leibniz_pi_sequencer_if.sv
// Start/done division handshake between the sequencer (master) and calc_decimal (slave).
interface leibniz_pi_sequencer_if #(
    parameter int P_WIDTH_IN   = 16,
    parameter int P_WIDTH_FRAC = 16
);
    logic                    div_start;
    logic [P_WIDTH_IN-1:0]   div_numerator;
    logic [P_WIDTH_IN-1:0]   div_denominator;
    logic                    div_done;
    logic [P_WIDTH_FRAC-1:0] div_decimal;

    modport master (
        output div_start, div_numerator, div_denominator,
        input  div_done, div_decimal
    );

    modport slave (
        input  div_start, div_numerator, div_denominator,
        output div_done, div_decimal
    );
endinterface

// File: rtl/leibniz_pi_sequencer.sv
// Leibniz series sequencer: issues 1/(2k+1) to calc_decimal, accumulates the alternating
// fractions in Q1.16 and reports 4*sum as unsigned Q3.16.
module leibniz_pi_sequencer
    import leibniz_pi_sequencer_pkg::*;
#(
    parameter int P_WIDTH_IN   = L_WIDTH_IN_DEF,
    parameter int P_WIDTH_FRAC = L_WIDTH_FRAC_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [P_WIDTH_IN-2:0]   num_terms_in,
    output logic                    busy,
    output logic                    done,
    output logic [P_WIDTH_FRAC+2:0] pi_out,
    leibniz_pi_sequencer_if.master  div
);

    localparam int ACC_W = P_WIDTH_FRAC + 2;
    localparam logic [ACC_W-1:0]      ONE_Q  = {1'b0, 1'b1, {P_WIDTH_FRAC{1'b0}}};
    localparam logic [P_WIDTH_IN-1:0] K_ONE  = {{(P_WIDTH_IN-1){1'b0}}, 1'b1};
    localparam logic [P_WIDTH_IN-2:0] N_ZERO = {(P_WIDTH_IN-1){1'b0}};

    logic [2:0]                state_r;
    logic signed [ACC_W-1:0]   acc_r;
    logic [P_WIDTH_IN-1:0]     k_r;
    logic [P_WIDTH_IN-2:0]     n_r;
    logic [P_WIDTH_FRAC-1:0]   term_r;
    logic                      div_done_q_r;
    logic                      busy_r;
    logic                      done_r;
    logic [P_WIDTH_FRAC+2:0]   pi_r;
    logic                      div_start_r;
    logic [P_WIDTH_IN-1:0]     div_num_r;
    logic [P_WIDTH_IN-1:0]     div_den_r;

    logic signed [ACC_W-1:0]   term_ext_s;
    logic                      div_done_rise_s;
    logic                      k_eq_n_s;

    assign term_ext_s      = $signed({2'b00, term_r});
    assign div_done_rise_s = div.div_done & ~div_done_q_r;
    assign k_eq_n_s        = (k_r == {1'b0, n_r});

    assign busy                = busy_r;
    assign done                = done_r;
    assign pi_out              = pi_r;
    assign div.div_start       = div_start_r;
    assign div.div_numerator   = div_num_r;
    assign div.div_denominator = div_den_r;

    // Previous div_done level, so a multi-cycle done pulse is consumed only once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_done_q_r <= 1'b0;
        end else begin
            div_done_q_r <= div.div_done;
        end
    end

    // Sequencer FSM, accumulator and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            acc_r       <= '0;
            k_r         <= '0;
            n_r         <= '0;
            term_r      <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pi_r        <= '0;
            div_start_r <= 1'b0;
            div_num_r   <= '0;
            div_den_r   <= '0;
        end else begin
            done_r      <= 1'b0;
            div_start_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    // done_r high here means FIN was last cycle: a coincident start is dropped.
                    if (start && !done_r) begin
                        n_r    <= num_terms_in;
                        busy_r <= 1'b1;
                        if (num_terms_in == N_ZERO) begin
                            acc_r   <= '0;
                            state_r <= S_FIN;
                        end else begin
                            acc_r   <= ONE_Q;
                            k_r     <= K_ONE;
                            state_r <= S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (k_eq_n_s) begin
                        state_r <= S_FIN;
                    end else begin
                        div_start_r <= 1'b1;
                        div_num_r   <= K_ONE;
                        div_den_r   <= {k_r[P_WIDTH_IN-2:0], 1'b1};
                        state_r     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state_r <= S_WAIT;
                end
                S_WAIT: begin
                    if (div_done_rise_s) begin
                        term_r  <= div.div_decimal;
                        state_r <= S_ACC;
                    end
                end
                S_ACC: begin
                    acc_r   <= k_r[0] ? (acc_r - term_ext_s) : (acc_r + term_ext_s);
                    k_r     <= k_r + K_ONE;
                    state_r <= S_CHECK;
                end
                S_FIN: begin
                    pi_r    <= {acc_r[P_WIDTH_FRAC:0], 2'b00};
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_leibniz_pi_sequencer.sv
// Directed bench for leibniz_pi_sequencer with a behavioural calc_decimal of random latency.
module tb_leibniz_pi_sequencer;
    import leibniz_pi_sequencer_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [14:0]       num_terms_in = 15'd0;
    logic              busy;
    logic              done;
    logic [L_PI_W-1:0] pi_out;

    int checks = 0;
    int failures = 0;

    bit   model_clr = 1'b1;
    int   force_lat = 0;
    int   pulse_len = 0;
    int   m_state = 0;
    int   m_cnt = 0;
    int   m_pulse = 0;
    logic [15:0] m_den = 16'd1;
    logic [15:0] m_num = 16'd0;
    int   ds_count = 0;
    int   mid_start_at = -1;
    bit   busy_always;
    logic [15:0] den_log[$];
    logic [15:0] num_log[$];

    leibniz_pi_sequencer_if #(.P_WIDTH_IN(16), .P_WIDTH_FRAC(16)) div_if ();

    leibniz_pi_sequencer #(.P_WIDTH_IN(16), .P_WIDTH_FRAC(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .num_terms_in (num_terms_in),
        .busy         (busy),
        .done         (done),
        .pi_out       (pi_out),
        .div          (div_if.master)
    );

    always #5 clk = ~clk;

    // Behavioural calc_decimal: random 1-20 cycle latency, 1-3 cycle done pulse.
    always @(posedge clk) begin
        if (model_clr) begin
            m_state              <= 0;
            div_if.div_done      <= 1'b0;
            div_if.div_decimal   <= 16'h0000;
        end else begin
            case (m_state)
                0: begin
                    div_if.div_done <= 1'b0;
                    if (div_if.div_start === 1'b1) begin
                        m_den   <= div_if.div_denominator;
                        m_num   <= div_if.div_numerator;
                        m_cnt   <= (force_lat != 0) ? force_lat : int'($urandom_range(20, 1));
                        m_state <= 1;
                    end
                end
                1: begin
                    if (m_cnt <= 1) begin
                        div_if.div_done    <= 1'b1;
                        div_if.div_decimal <= 16'(({16'h0000, m_num} << 16) / {16'h0000, m_den});
                        m_pulse <= (pulse_len != 0) ? pulse_len : int'($urandom_range(3, 1));
                        m_state <= 2;
                    end else begin
                        m_cnt <= m_cnt - 1;
                    end
                end
                2: begin
                    if (m_pulse <= 1) begin
                        div_if.div_done <= 1'b0;
                        m_state         <= 0;
                    end else begin
                        m_pulse <= m_pulse - 1;
                    end
                end
                default: m_state <= 0;
            endcase
        end
    end

    // Counts every div_start pulse the sequencer issues.
    always @(posedge clk) begin
        if (div_if.div_start === 1'b1) ds_count <= ds_count + 1;
    end

    task automatic start_run(input logic [14:0] n);
        @(negedge clk);
        num_terms_in = n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns at the negedge where done is seen; lat counts cycles from the start cycle.
    task automatic wait_done(input int limit, output int lat, output bit ok);
        lat = 1;
        ok = 1'b0;
        busy_always = 1'b1;
        den_log.delete();
        num_log.delete();
        for (int i = 0; i < limit; i++) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            if (busy !== 1'b1) busy_always = 1'b0;
            if (div_if.div_start === 1'b1) begin
                den_log.push_back(div_if.div_denominator);
                num_log.push_back(div_if.div_numerator);
            end
            start = (lat == mid_start_at);
            num_terms_in = (lat == mid_start_at) ? 15'd5 : num_terms_in;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy actual=%b expected=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done actual=%b expected=0", done); end
        checks++; if (pi_out !== 19'h0) begin failures++; $display("FAIL reset_pi actual=%h expected=0", pi_out); end
        checks++; if (div_if.div_start !== 1'b0) begin failures++; $display("FAIL reset_div_start actual=%b expected=0", div_if.div_start); end
        checks++; if (div_if.div_numerator !== 16'h0) begin failures++; $display("FAIL reset_div_num actual=%h expected=0", div_if.div_numerator); end
        checks++; if (div_if.div_denominator !== 16'h0) begin failures++; $display("FAIL reset_div_den actual=%h expected=0", div_if.div_denominator); end
        rst_n = 1'b1;
        model_clr = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_n1();
        int lat; bit ok; int ds0;
        ds0 = ds_count;
        start_run(15'd1);
        wait_done(50, lat, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL n1_timeout actual=%0d expected=1", ok); end
        checks++; if (lat !== 3) begin failures++; $display("FAIL n1_latency actual=%0d expected=3", lat); end
        checks++; if (pi_out !== 19'h40000) begin failures++; $display("FAIL n1_pi actual=%h expected=40000", pi_out); end
        checks++; if (busy_always !== 1'b1) begin failures++; $display("FAIL n1_busy_run actual=%b expected=1", busy_always); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL n1_busy_at_done actual=%b expected=0", busy); end
        checks++; if (ds_count - ds0 !== 0) begin failures++; $display("FAIL n1_div_starts actual=%0d expected=0", ds_count - ds0); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL n1_done_pulse actual=%b expected=0", done); end
    endtask

    task automatic test_n0();
        int lat; bit ok; int ds0;
        ds0 = ds_count;
        start_run(15'd0);
        wait_done(50, lat, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL n0_timeout actual=%0d expected=1", ok); end
        checks++; if (lat !== 2) begin failures++; $display("FAIL n0_latency actual=%0d expected=2", lat); end
        checks++; if (pi_out !== 19'h0) begin failures++; $display("FAIL n0_pi actual=%h expected=0", pi_out); end
        checks++; if (ds_count - ds0 !== 0) begin failures++; $display("FAIL n0_div_starts actual=%0d expected=0", ds_count - ds0); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat; bit ok; int ds0;
        start_run(15'd2);
        wait_done(200, lat, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL n2_timeout actual=%0d expected=1", ok); end
        checks++; if (pi_out !== 19'h2AAAC) begin failures++; $display("FAIL n2_pi actual=%h expected=2aaac", pi_out); end
        checks++; if (den_log.size() !== 1 || den_log[0] !== 16'd3) begin failures++; $display("FAIL n2_den actual=%0d/%h expected=1/0003", den_log.size(), (den_log.size() > 0) ? den_log[0] : 16'hxxxx); end
        checks++; if (num_log.size() !== 1 || num_log[0] !== 16'd1) begin failures++; $display("FAIL n2_num actual=%0d entries expected numerator 1", num_log.size()); end
        // start coincident with done must be dropped
        ds0 = ds_count;
        num_terms_in = 15'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL start_on_done_busy actual=%b expected=0", busy); end
        repeat (4) @(negedge clk);
        checks++; if (done !== 1'b0 || pi_out !== 19'h2AAAC) begin failures++; $display("FAIL start_on_done_run actual=%b/%h expected=0/2aaac", done, pi_out); end
        checks++; if (ds_count - ds0 !== 0) begin failures++; $display("FAIL start_on_done_divs actual=%0d expected=0", ds_count - ds0); end
    endtask

    task automatic test_long_pulse();
        int lat; bit ok;
        pulse_len = 3;
        start_run(15'd3);
        wait_done(300, lat, ok);
        pulse_len = 0;
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL n3_timeout actual=%0d expected=1", ok); end
        checks++; if (pi_out !== 19'h37778) begin failures++; $display("FAIL n3_pi actual=%h expected=37778", pi_out); end
        checks++; if (den_log.size() !== 2) begin failures++; $display("FAIL n3_div_count actual=%0d expected=2", den_log.size()); end
        else begin
            checks++; if (den_log[0] !== 16'd3 || den_log[1] !== 16'd5) begin failures++; $display("FAIL n3_dens actual=%h,%h expected=0003,0005", den_log[0], den_log[1]); end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_n1000();
        int lat; bit ok; int ds0;
        int exp_acc; int t; real ref_sum; real got; real diff;
        exp_acc = int'(L_ONE_Q);
        ref_sum = 1.0;
        for (int k = 1; k < 1000; k++) begin
            t = 65536 / (2 * k + 1);
            exp_acc = (k % 2 == 1) ? exp_acc - t : exp_acc + t;
            ref_sum = (k % 2 == 1) ? ref_sum - 1.0 / (2.0 * k + 1.0) : ref_sum + 1.0 / (2.0 * k + 1.0);
        end
        ds0 = ds_count;
        mid_start_at = 500;
        start_run(15'd1000);
        wait_done(40000, lat, ok);
        mid_start_at = -1;
        got = real'(pi_out) / 65536.0;
        diff = got - 4.0 * ref_sum;
        if (diff < 0.0) diff = -diff;
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL n1000_timeout actual=%0d expected=1", ok); end
        checks++; if (ds_count - ds0 !== 999) begin failures++; $display("FAIL n1000_div_starts actual=%0d expected=999", ds_count - ds0); end
        checks++; if (pi_out !== 19'(exp_acc * 4)) begin failures++; $display("FAIL n1000_pi actual=%h expected=%h", pi_out, 19'(exp_acc * 4)); end
        checks++; if (diff > 1.0 / 64.0) begin failures++; $display("FAIL n1000_tol actual=%f expected=%f", got, 4.0 * ref_sum); end
        checks++; if (busy_always !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL n1000_busy actual=%b/%b expected=1/0", busy_always, busy); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL n1000_done_pulse actual=%b expected=0", done); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int lat; bit ok; bit seen; bit stray;
        force_lat = 15;
        start_run(15'd100);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (div_if.div_start === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL rst_mid_issue actual=%b expected=1", seen); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || pi_out !== 19'h0) begin failures++; $display("FAIL rst_mid_outputs actual=%b/%b/%h expected=0/0/0", busy, done, pi_out); end
        checks++; if (div_if.div_start !== 1'b0 || div_if.div_denominator !== 16'h0 || div_if.div_numerator !== 16'h0) begin failures++; $display("FAIL rst_mid_div actual=%b/%h/%h expected=0/0/0", div_if.div_start, div_if.div_numerator, div_if.div_denominator); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stray = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (busy !== 1'b0 || done !== 1'b0 || pi_out !== 19'h0) stray = 1'b1;
            @(negedge clk);
        end
        checks++; if (m_state !== 0) begin failures++; $display("FAIL rst_mid_model_idle actual=%0d expected=0", m_state); end
        checks++; if (stray !== 1'b0) begin failures++; $display("FAIL rst_mid_late_done actual=%b expected=0", stray); end
        force_lat = 0;
        start_run(15'd2);
        wait_done(200, lat, ok);
        checks++; if (ok !== 1'b1 || pi_out !== 19'h2AAAC) begin failures++; $display("FAIL rst_mid_rerun actual=%0d/%h expected=1/2aaac", ok, pi_out); end
    endtask

    initial begin
        test_reset();
        test_n1();
        test_n0();
        test_back_to_back();
        test_long_pulse();
        test_n1000();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
